div_unit: RTL

//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) paired with the combinational ALU in EX.

---
 rtl/div_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit -- multi-cycle RV32M divider (DIV / DIVU / REM / REMU).
//
// Radix-2 restoring division, one quotient bit per clock. It sits next to
// the EX-stage ALU: EX stalls while in_ready=0 or while it waits for
// out_valid, and the result is muxed onto the ALU result path.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid         in_ready   idle, can take a request
//   a, b       dividend / divisor    op         00 DIV 01 DIVU 10 REM 11 REMU
//   kill       abort the in-flight operation (CALC or DONE -> IDLE)
//   out_valid  result valid (DONE)   out_ready  consumer takes the result
//   out        registered quotient or remainder
//   busy       unit not idle
//
// Build option
//   DIV_EARLY_OUT_EN : divide-by-zero and signed overflow skip the
//   iterations and go straight to DONE (result one cycle after accept).
//   Without it every operation takes WIDTH CALC cycles; the results are
//   identical either way.

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Everything about the request that is still needed at DONE entry.
    typedef struct packed {
        logic             is_rem;
        logic             neg_q;
        logic             neg_r;
        logic             special;
        logic [WIDTH-1:0] spec_res;
    } req_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits enter the bottom
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    req_t             req;

    // ---------------- request decode ----------------
    logic             sgn_in, rem_in, a_neg, b_neg, b_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag;
    req_t             req_in;

    assign sgn_in = ~op[0];
    assign rem_in = op[1];
    assign a_neg  = sgn_in & a[WIDTH-1];
    assign b_neg  = sgn_in & b[WIDTH-1];
    // Two's-complement negation read back as unsigned: -(-2^(W-1)) gives
    // the bit pattern 2^(W-1), which is the exact magnitude.
    assign a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    assign b_zero = (b == '0);
    assign ovf    = sgn_in & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);

    always_comb begin
        req_in          = '0;
        req_in.is_rem   = rem_in;
        req_in.neg_q    = a_neg ^ b_neg;
        req_in.neg_r    = a_neg;
        req_in.special  = b_zero | ovf;
        if (b_zero)
            req_in.spec_res = rem_in ? a : '1;
        else
            req_in.spec_res = rem_in ? '0 : a;
    end

    // ---------------- one restoring step ----------------
    // The shifted remainder needs WIDTH+1 bits: for an unsigned divisor
    // above 2^(W-1) it can exceed WIDTH bits before the subtract.
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_res, r_res, fin_res;

    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign qbit    = ~rem_sub[WIDTH];          // no borrow -> rem_sh >= dvs
    assign rem_nx  = qbit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx  = {dvd[WIDTH-2:0], qbit};

    // Sign fix-up applied to the values the last step produces.
    assign q_res   = req.neg_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
    assign r_res   = req.neg_r ? (~rem_nx + WIDTH'(1)) : rem_nx;
    assign fin_res = req.special ? req.spec_res : (req.is_rem ? r_res : q_res);

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            req       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // kill also blocks acceptance of a request in IDLE
                    if (in_valid && !kill) begin
                        req      <= req_in;
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (EARLY_OUT && req_in.special) begin
                            state     <= DONE;
                            out       <= req_in.spec_res;
                            out_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        rem <= rem_nx;
                        dvd <= quo_nx;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH-1)) begin
                            state     <= DONE;
                            out       <= fin_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // out holds its value; only the handshake or a kill leaves
                    if (kill || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
